// File: rtl/fir_sm_fifo.sv
// fir_sm_fifo: output buffer behind the FIR stream master.
// First-word fall-through FIFO with a 3-state frame controller.
// Also checks that tlast lands on the configured frame length.
module fir_sm_fifo #(
    parameter int pDATA_WIDTH = 32,
    parameter int pDEPTH      = 16,
    parameter int pLVL_WIDTH  = 5
) (
    input  logic                   axis_clk,
    input  logic                   axis_rst_n,
    input  logic [pDATA_WIDTH-1:0] s_tdata,
    input  logic                   s_tvalid,
    output logic                   s_tready,
    input  logic                   s_tlast,
    output logic [pDATA_WIDTH-1:0] m_tdata,
    output logic                   m_tvalid,
    input  logic                   m_tready,
    output logic                   m_tlast,
    input  logic [31:0]            cfg_data_length,
    input  logic                   cfg_clear,
    output logic [pLVL_WIDTH-1:0]  stat_level,
    output logic                   stat_full,
    output logic                   stat_empty,
    output logic [31:0]            stat_frame_cnt,
    output logic                   stat_tlast_err,
    output logic                   stat_frame_done
);

    localparam int ADDR_W = pLVL_WIDTH - 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_t;

    logic [pDATA_WIDTH:0]  mem [pDEPTH];
    logic [pLVL_WIDTH-1:0] wr_ptr, rd_ptr;
    logic [ADDR_W-1:0]     wr_addr, rd_addr;
    logic [31:0]           beat_cnt;
    state_t                state;
    logic                  empty, full, push, pop, expected_last;

    assign wr_addr = wr_ptr[ADDR_W-1:0];
    assign rd_addr = rd_ptr[ADDR_W-1:0];

    // Extra pointer MSB distinguishes full from empty when the addresses match.
    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[ADDR_W] != rd_ptr[ADDR_W]) && (wr_addr == rd_addr);

    // Ready depends only on registered state, so no combinational path from m_tready.
    assign s_tready = !full && (state != DRAIN);
    assign m_tvalid = !empty;
    assign m_tdata  = empty ? '0 : mem[rd_addr][pDATA_WIDTH-1:0];
    assign m_tlast  = !empty && mem[rd_addr][pDATA_WIDTH];

    // A clear in the same cycle wins, so any coincident handshake is dropped.
    assign push = s_tvalid && s_tready && !cfg_clear;
    assign pop  = m_tvalid && m_tready && !cfg_clear;

    assign expected_last = ((beat_cnt + 32'd1) == cfg_data_length);

    assign stat_level = wr_ptr - rd_ptr;
    assign stat_full  = full;
    assign stat_empty = empty;

    // Sample storage: write the accepted beat at the tail.
    // NOTE: the array has no reset; the pointers alone say which entries are valid,
    // so clearing the storage would only cost flops and reset fan-out.
    always_ff @(posedge axis_clk) begin
        if (push) begin
            mem[wr_addr] <= {s_tlast, s_tdata};
        end
    end

    // Pointer update; both may advance in one cycle, leaving the level unchanged.
    // NOTE: sequential state uses non-blocking assignments so every flop samples
    // pre-edge values regardless of block ordering.
    always_ff @(posedge axis_clk or negedge axis_rst_n) begin
        if (!axis_rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else if (cfg_clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    // Input-side beat counter and sticky tlast/length mismatch flag.
    always_ff @(posedge axis_clk or negedge axis_rst_n) begin
        if (!axis_rst_n) begin
            beat_cnt       <= '0;
            stat_tlast_err <= 1'b0;
        end else if (cfg_clear) begin
            beat_cnt       <= '0;
            stat_tlast_err <= 1'b0;
        end else if (push) begin
            beat_cnt <= s_tlast ? 32'd0 : beat_cnt + 32'd1;
            if ((cfg_data_length != 32'd0) && (s_tlast != expected_last)) begin
                stat_tlast_err <= 1'b1;
            end
        end
    end

    // Frame controller plus registered completion pulse and frame counter.
    always_ff @(posedge axis_clk or negedge axis_rst_n) begin
        if (!axis_rst_n) begin
            state           <= IDLE;
            stat_frame_done <= 1'b0;
            stat_frame_cnt  <= '0;
        end else if (cfg_clear) begin
            state           <= IDLE;
            stat_frame_done <= 1'b0;
            stat_frame_cnt  <= '0;
        end else begin
            case (state)
                IDLE:    if (push) state <= s_tlast ? DRAIN : RUN;
                RUN:     if (push && s_tlast) state <= DRAIN;
                DRAIN:   if (pop && m_tlast) state <= IDLE;
                default: state <= IDLE;
            endcase
            stat_frame_done <= pop && m_tlast;
            if (pop && m_tlast) begin
                stat_frame_cnt <= stat_frame_cnt + 32'd1;
            end
        end
    end

endmodule

// File: tb/tb_fir_sm_fifo.sv
// Self-checking bench for fir_sm_fifo: directed scenarios plus random traffic,
// compared every cycle against a queue-based reference model.
module tb_fir_sm_fifo;

    localparam int DW    = 32;
    localparam int DEPTH = 16;
    localparam int LW    = 5;

    logic          axis_clk, axis_rst_n;
    logic [DW-1:0] s_tdata;
    logic          s_tvalid, s_tready, s_tlast;
    logic [DW-1:0] m_tdata;
    logic          m_tvalid, m_tready, m_tlast;
    logic [31:0]   cfg_data_length;
    logic          cfg_clear;
    logic [LW-1:0] stat_level;
    logic          stat_full, stat_empty;
    logic [31:0]   stat_frame_cnt;
    logic          stat_tlast_err, stat_frame_done;

    fir_sm_fifo #(.pDATA_WIDTH(DW), .pDEPTH(DEPTH), .pLVL_WIDTH(LW)) dut (
        .axis_clk        (axis_clk),
        .axis_rst_n      (axis_rst_n),
        .s_tdata         (s_tdata),
        .s_tvalid        (s_tvalid),
        .s_tready        (s_tready),
        .s_tlast         (s_tlast),
        .m_tdata         (m_tdata),
        .m_tvalid        (m_tvalid),
        .m_tready        (m_tready),
        .m_tlast         (m_tlast),
        .cfg_data_length (cfg_data_length),
        .cfg_clear       (cfg_clear),
        .stat_level      (stat_level),
        .stat_full       (stat_full),
        .stat_empty      (stat_empty),
        .stat_frame_cnt  (stat_frame_cnt),
        .stat_tlast_err  (stat_tlast_err),
        .stat_frame_done (stat_frame_done)
    );

    initial axis_clk = 1'b0;
    always #5 axis_clk = ~axis_clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: contents as a queue of {tlast, data}, plus frame statistics.
    logic [DW:0] q[$];
    int          m_beat;
    bit          m_err;
    logic [31:0] m_cnt;
    bit          m_done;

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
        end
    endtask

    function automatic bit holds_tlast();
        foreach (q[i]) if (q[i][DW]) return 1'b1;
        return 1'b0;
    endfunction

    // Input is accepted while there is room and no completed frame is still queued.
    function automatic bit model_ready();
        return (q.size() < DEPTH) && !holds_tlast();
    endfunction

    task automatic model_reset();
        q.delete();
        m_beat = 0;
        m_err  = 1'b0;
        m_cnt  = '0;
        m_done = 1'b0;
    endtask

    task automatic check_outputs();
        check("m_tvalid", m_tvalid, q.size() != 0);
        if (q.size() != 0) begin
            check("m_tdata", m_tdata, q[0][DW-1:0]);
            check("m_tlast", m_tlast, q[0][DW]);
        end
        check("s_tready", s_tready, model_ready());
        check("level", stat_level, q.size());
        check("full", stat_full, q.size() == DEPTH);
        check("empty", stat_empty, q.size() == 0);
        check("frame_cnt", stat_frame_cnt, m_cnt);
        check("tlast_err", stat_tlast_err, m_err);
        check("frame_done", stat_frame_done, m_done);
    endtask

    // One clock: drive at negedge, update model at posedge, check at next negedge.
    task automatic step(input logic v, input logic [DW-1:0] d, input logic l,
                        input logic r, input logic c);
        bit do_push, do_pop;
        s_tvalid  = v;
        s_tdata   = d;
        s_tlast   = l;
        m_tready  = r;
        cfg_clear = c;
        do_push = v && model_ready();
        do_pop  = r && (q.size() != 0);
        @(posedge axis_clk);
        if (c) begin
            model_reset();
        end else begin
            m_done = do_pop && q[0][DW];
            if (m_done) m_cnt = m_cnt + 32'd1;
            if (do_push) begin
                if (cfg_data_length != 0 && (l != (32'(m_beat + 1) == cfg_data_length)))
                    m_err = 1'b1;
                m_beat = l ? 0 : m_beat + 1;
            end
            if (do_pop)  void'(q.pop_front());
            if (do_push) q.push_back({l, d});
        end
        @(negedge axis_clk);
        check_outputs();
    endtask

    // Send n beats with tlast every flen beats; consumer stalls for the first hold cycles.
    task automatic run_frames(input int n, input int flen, input int hold, input int base);
        int sent = 0;
        int cyc  = 0;
        while ((sent < n || q.size() != 0) && cyc < 400) begin
            bit v, pushed;
            v = (sent < n);
            pushed = v && model_ready();
            step(v, DW'(base + sent), (sent % flen) == (flen - 1), cyc >= hold, 1'b0);
            if (pushed) sent++;
            cyc++;
        end
        check("frame_timeout", cyc < 400, 1'b1);
    endtask

    initial begin
        int flen;
        axis_rst_n      = 1'b0;
        s_tvalid        = 1'b0;
        s_tdata         = '0;
        s_tlast         = 1'b0;
        m_tready        = 1'b0;
        cfg_clear       = 1'b0;
        cfg_data_length = 32'd4;
        model_reset();
        repeat (2) @(negedge axis_clk);
        check("rst_m_tdata", m_tdata, 0);
        axis_rst_n = 1'b1;
        @(negedge axis_clk);
        check_outputs();

        // Clean 4-beat frame, streaming consumer.
        run_frames(4, 4, 0, 1);
        check("t1_cnt", stat_frame_cnt, 1);

        // 20-beat frame into a stalled consumer: fills, then drains in order.
        cfg_data_length = 32'd20;
        run_frames(20, 20, 18, 100);

        // Early tlast on beat 2 of 3 with length 3: sticky error, DRAIN holds beat 3.
        cfg_data_length = 32'd3;
        run_frames(3, 2, 0, 200);
        check("t3_err_sticky", stat_tlast_err, 1'b1);
        step(1'b0, '0, 1'b0, 1'b1, 1'b1);

        // Two back-to-back 2-beat frames.
        cfg_data_length = 32'd2;
        run_frames(4, 2, 0, 300);
        check("t4_cnt", stat_frame_cnt, 2);

        // Clear mid-frame together with a push and a pop.
        cfg_data_length = 32'd8;
        for (int i = 0; i < 3; i++) step(1'b1, DW'(400 + i), 1'b0, 1'b0, 1'b0);
        step(1'b1, 32'd999, 1'b0, 1'b1, 1'b1);
        check("t5_level", stat_level, 0);
        repeat (2) step(1'b0, '0, 1'b0, 1'b1, 1'b0);

        // Short asynchronous reset pulse mid-frame.
        for (int i = 0; i < 2; i++) step(1'b1, DW'(500 + i), 1'b0, 1'b0, 1'b0);
        s_tvalid = 1'b0;
        m_tready = 1'b0;
        #1 axis_rst_n = 1'b0;
        #1;
        check("arst_m_tvalid", m_tvalid, 1'b0);
        check("arst_level", stat_level, 0);
        check("arst_s_tready", s_tready, 1'b1);
        #1 axis_rst_n = 1'b1;
        model_reset();
        @(negedge axis_clk);
        check_outputs();
        cfg_data_length = 32'd4;
        run_frames(4, 4, 0, 600);

        // Random traffic with occasional length changes and clears.
        flen = 4;
        for (int i = 0; i < 3000; i++) begin
            bit v, r, c, l;
            if ($urandom_range(49) == 0) begin
                case ($urandom_range(3))
                    0:       cfg_data_length = 32'd0;
                    1:       cfg_data_length = 32'd3;
                    2:       cfg_data_length = 32'd4;
                    default: cfg_data_length = 32'd5;
                endcase
            end
            v = ($urandom_range(3) != 0);
            r = ($urandom_range(2) != 0);
            c = ($urandom_range(99) == 0);
            l = ((m_beat + 1) >= flen);
            if (v && !c && model_ready() && l) flen = $urandom_range(6, 1);
            step(v, $urandom, l, r, c);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
